// File: rtl/counter_sequencer_if.sv
// rtl/counter_sequencer_if.sv - command and counter-side signal bundle for counter_sequencer
//
// Purpose: groups the command handshake, the counter request/response signals and
// the status outputs of counter_sequencer into one bundle.
// Modports:
//   master - environment side: offers commands, returns counter Ready/Zero, observes status
//   slave  - sequencer side: accepts commands, drives counter controls and status
// Signals:
//   CmdValid/CmdReady/CmdOp/CmdCount/CmdData    command handshake and payload
//   CntRequest/CntDec/CntSet/CntIn              controls towards the counter
//   CntReady/CntZero                            counter status
//   Done/Error/Steps                            completion status
interface counter_sequencer_if #(
  parameter int DW          = 18,
  parameter int COUNT_WIDTH = 8
);
  logic                   CmdValid;
  logic                   CmdReady;
  logic [1:0]             CmdOp;
  logic [COUNT_WIDTH-1:0] CmdCount;
  logic [DW-1:0]          CmdData;
  logic                   CntRequest;
  logic                   CntDec;
  logic                   CntSet;
  logic [DW-1:0]          CntIn;
  logic                   CntReady;
  logic                   CntZero;
  logic                   Done;
  logic                   Error;
  logic [COUNT_WIDTH-1:0] Steps;

  modport master (
    output CmdValid, CmdOp, CmdCount, CmdData, CntReady, CntZero,
    input  CmdReady, CntRequest, CntDec, CntSet, CntIn, Done, Error, Steps
  );

  modport slave (
    input  CmdValid, CmdOp, CmdCount, CmdData, CntReady, CntZero,
    output CmdReady, CntRequest, CntDec, CntSet, CntIn, Done, Error, Steps
  );
endinterface

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - command sequencer driving one dekatron counter
//
// Purpose: accepts one INC/DEC/SET/DZ command with a repeat count and issues
// single-cycle requests to the counter, waiting for its Ready between steps, until
// the count is used up, the counter reports zero (DZ only) or a timeout fires.
// Ports:
//   Clk    - clock, rising edge
//   Rst_n  - asynchronous active-low reset
//   bus    - counter_sequencer_if.slave: command handshake, counter controls, status
module counter_sequencer #(
  parameter int DEKATRON_NUM   = 6,
  parameter int DEKATRON_WIDTH = 3,
  parameter int COUNT_WIDTH    = 8,
  parameter int TIMEOUT        = 15
) (
  input  logic                Clk,
  input  logic                Rst_n,
  counter_sequencer_if.slave  bus
);
  localparam int DW = DEKATRON_NUM * DEKATRON_WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_DZ  = 2'b11;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             op_q;
  logic [DW-1:0]          data_q;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [COUNT_WIDTH-1:0] steps_q;
  logic                   err_q;
  logic [TW-1:0]          tmo_q;

  logic check_end;
  logic tmo_hit;
  logic active;

  // A command ends at CHECK when its count is used up; DZ also stops once the
  // counter already reads zero, so it never decrements past zero.
  assign check_end = (remaining == '0) || ((op_q == OP_DZ) && bus.CntZero);
  // This stall cycle would be the TIMEOUT-th consecutive one without Ready.
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign active    = (state != S_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.CmdValid) state_nxt = S_CHECK;
      S_CHECK: begin
        if (check_end)         state_nxt = S_DONE;
        else if (bus.CntReady) state_nxt = S_ISSUE;
        else if (tmo_hit)      state_nxt = S_DONE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.CntReady)      state_nxt = S_CHECK;
        else if (tmo_hit)      state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q      <= OP_INC;
      data_q    <= '0;
      remaining <= '0;
      steps_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.CmdValid) begin
            op_q      <= bus.CmdOp;
            data_q    <= bus.CmdData;
            remaining <= (bus.CmdOp == OP_SET) ? COUNT_WIDTH'(1) : bus.CmdCount;
            steps_q   <= '0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
          end
        end
        S_CHECK: begin
          if (!check_end) begin
            if (bus.CntReady) tmo_q <= '0;
            else if (tmo_hit) err_q <= 1'b1;
            else              tmo_q <= tmo_q + TW'(1);
          end
        end
        S_ISSUE: begin
          remaining <= remaining - COUNT_WIDTH'(1);
          steps_q   <= steps_q + COUNT_WIDTH'(1);
          tmo_q     <= '0;
        end
        S_WAIT: begin
          if (bus.CntReady) tmo_q <= '0;
          else if (tmo_hit) err_q <= 1'b1;
          else              tmo_q <= tmo_q + TW'(1);
        end
        default: ;
      endcase
    end
  end

  // Counter controls are derived from the latched command, so they are stable
  // from the accept edge until the return to IDLE and around every request.
  assign bus.CmdReady   = (state == S_IDLE);
  assign bus.CntRequest = (state == S_ISSUE);
  assign bus.CntDec     = active && ((op_q == OP_DEC) || (op_q == OP_DZ));
  assign bus.CntSet     = active && (op_q == OP_SET);
  assign bus.CntIn      = active ? data_q : '0;
  assign bus.Done       = (state == S_DONE);
  assign bus.Error      = err_q;
  assign bus.Steps      = steps_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - scoreboard testbench for counter_sequencer with a counter stub
module tb_counter_sequencer;
  localparam int DEKATRON_NUM   = 6;
  localparam int DEKATRON_WIDTH = 3;
  localparam int COUNT_WIDTH    = 8;
  localparam int TIMEOUT        = 15;
  localparam int COUNT_DELAY    = 3;
  localparam int DW             = DEKATRON_NUM * DEKATRON_WIDTH;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_DZ  = 2'b11;

  typedef struct {
    int            steps;
    bit            err;
    logic [DW-1:0] out;
    bit            dec;
    bit            set;
  } exp_t;

  logic Clk;
  logic Rst_n;

  counter_sequencer_if #(.DW(DW), .COUNT_WIDTH(COUNT_WIDTH)) bus ();

  counter_sequencer #(
    .DEKATRON_NUM   (DEKATRON_NUM),
    .DEKATRON_WIDTH (DEKATRON_WIDTH),
    .COUNT_WIDTH    (COUNT_WIDTH),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Counter stub: a request drops Ready for COUNT_DELAY cycles, then the value
  // is updated and Ready returns (unless stub_hang holds it low).
  logic [DW-1:0] cnt_val = '0;
  logic          cnt_ready = 1'b1;
  int            busy = 0;
  logic          pend_set = 1'b0;
  logic          pend_dec = 1'b0;
  logic [DW-1:0] pend_in = '0;
  logic          stub_hang;
  logic          stub_load;
  logic [DW-1:0] stub_load_val;

  assign bus.CntReady = cnt_ready;
  assign bus.CntZero  = (cnt_val == '0);

  always @(posedge Clk) begin
    if (stub_load) begin
      cnt_val <= stub_load_val;
    end else if (bus.CntRequest) begin
      pend_set  <= bus.CntSet;
      pend_dec  <= bus.CntDec;
      pend_in   <= bus.CntIn;
      busy      <= COUNT_DELAY;
      cnt_ready <= 1'b0;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if (busy == 1) begin
      busy    <= 0;
      cnt_val <= pend_set ? pend_in : (pend_dec ? cnt_val - DW'(1) : cnt_val + DW'(1));
      if (!stub_hang) cnt_ready <= 1'b1;
    end else if (!stub_hang) begin
      cnt_ready <= 1'b1;
    end
  end

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   req_seen = 0;
  bit   prev_req = 1'b0;
  bit   prev_ready = 1'b0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  // Monitor: per-request protocol checks and scoreboard pop on every Done.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n) begin
      if (bus.CntRequest) begin
        req_seen++;
        check("req_back_to_back", prev_req, 0);
        check("req_after_ready", prev_ready, 1);
        if (exp_q.size() > 0) begin
          check("req_dec", bus.CntDec, exp_q[0].dec);
          check("req_set", bus.CntSet, exp_q[0].set);
        end
      end
      if (bus.Done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("done_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("steps", bus.Steps, e.steps);
          check("error", bus.Error, e.err);
          check("requests", req_seen, e.steps);
          check("counter_out", cnt_val, e.out);
          check("done_dec", bus.CntDec, e.dec);
          check("done_set", bus.CntSet, e.set);
        end
      end
      if (bus.CmdValid && bus.CmdReady) req_seen = 0;
    end
    prev_req   = bus.CntRequest;
    prev_ready = bus.CntReady;
  end

  task automatic preload(input logic [DW-1:0] v);
    stub_load     = 1'b1;
    stub_load_val = v;
    @(posedge Clk); #1;
    stub_load     = 1'b0;
  endtask

  // Drives one command in the posedge+1 phase; returns just after the accept edge.
  task automatic send_cmd(input logic [1:0] op, input int cnt, input logic [DW-1:0] data,
                          input bit push, input int e_steps, input bit e_err,
                          input logic [DW-1:0] e_out);
    exp_t e;
    int   n = 0;
    while (!bus.CmdReady && n < 2000) begin
      @(posedge Clk); #1;
      n++;
    end
    check("cmd_ready_wait", bus.CmdReady, 1);
    if (push) begin
      e.steps = e_steps;
      e.err   = e_err;
      e.out   = e_out;
      e.dec   = (op == OP_DEC) || (op == OP_DZ);
      e.set   = (op == OP_SET);
      exp_q.push_back(e);
    end
    bus.CmdValid = 1'b1;
    bus.CmdOp    = op;
    bus.CmdCount = COUNT_WIDTH'(cnt);
    bus.CmdData  = data;
    @(posedge Clk); #1;
    bus.CmdValid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge Clk); #1;
      n++;
    end
    check("done_wait", done_cnt >= target, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cnt_ready && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input int cnt, input logic [DW-1:0] data,
                         input int e_steps, input bit e_err, input logic [DW-1:0] e_out);
    int d0 = done_cnt;
    send_cmd(op, cnt, data, 1'b1, e_steps, e_err, e_out);
    wait_done(d0 + 1);
  endtask

  initial begin
    int d0;
    int n;
    bus.CmdValid = 1'b0;
    bus.CmdOp    = OP_INC;
    bus.CmdCount = '0;
    bus.CmdData  = '0;
    stub_hang    = 1'b0;
    stub_load    = 1'b0;
    stub_load_val = '0;
    Rst_n        = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_cmd_ready", bus.CmdReady, 1);
    check("rst_request", bus.CntRequest, 0);
    check("rst_dec", bus.CntDec, 0);
    check("rst_set", bus.CntSet, 0);
    check("rst_in", bus.CntIn, 0);
    check("rst_done", bus.Done, 0);
    check("rst_error", bus.Error, 0);
    check("rst_steps", bus.Steps, 0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    preload(0);
    run_cmd(OP_INC, 5, 0, 5, 0, 5);
    preload(3);
    run_cmd(OP_DZ, 255, 0, 3, 0, 0);
    run_cmd(OP_SET, 200, 12345, 1, 0, 12345);

    // Zero-count command timing
    send_cmd(OP_INC, 0, 0, 1'b1, 0, 0, 12345);
    check("zero_t1_done", bus.Done, 0);
    check("zero_t1_ready", bus.CmdReady, 0);
    @(posedge Clk); #1;
    check("zero_t2_done", bus.Done, 1);
    check("zero_t2_ready", bus.CmdReady, 0);
    @(posedge Clk); #1;
    check("zero_t3_done", bus.Done, 0);
    check("zero_t3_ready", bus.CmdReady, 1);

    // CmdValid held while a 4-step command runs
    d0 = done_cnt;
    send_cmd(OP_INC, 4, 0, 1'b1, 4, 0, 12349);
    send_cmd(OP_DEC, 1, 0, 1'b1, 1, 0, 12348);
    bus.CmdValid = 1'b1;
    bus.CmdOp    = OP_SET;
    bus.CmdCount = 8'd7;
    bus.CmdData  = 18'd99;
    n = 0;
    while (!bus.CmdReady && n < 500) begin
      @(posedge Clk); #1;
      n++;
    end
    bus.CmdValid = 1'b0;
    check("hold_done_before_accept", done_cnt, d0 + 2);
    check("hold_ready_no_accept", bus.CmdReady, 1);

    // DZ boundaries and DEC wrap below zero
    preload(0);
    run_cmd(OP_DZ, 5, 0, 0, 0, 0);
    preload(7);
    run_cmd(OP_DZ, 0, 0, 0, 0, 7);
    run_cmd(OP_DZ, 2, 0, 2, 0, 5);
    preload(0);
    run_cmd(OP_DEC, 2, 0, 2, 0, {DW{1'b1}} - DW'(1));

    // Stuck counter timeout
    preload(0);
    stub_hang = 1'b1;
    d0 = done_cnt;
    send_cmd(OP_INC, 3, 0, 1'b1, 1, 1, 1);
    n = 0;
    while (!bus.CntRequest && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    n = 0;
    while (!bus.Done && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check("tmo_latency", n, TIMEOUT + 1);
    @(posedge Clk); #1;
    check("tmo_done_count", done_cnt, d0 + 1);
    check("tmo_err_hold", bus.Error, 1);
    check("tmo_steps_hold", bus.Steps, 1);
    stub_hang = 1'b0;
    wait_ready();
    d0 = done_cnt;
    send_cmd(OP_INC, 1, 0, 1'b1, 1, 0, 2);
    check("err_clear_on_accept", bus.Error, 0);
    wait_done(d0 + 1);

    // Reset during WAIT of DEC 10
    preload(20);
    send_cmd(OP_DEC, 10, 0, 1'b0, 0, 0, 0);
    n = 0;
    while (!bus.CntRequest && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_request", bus.CntRequest, 0);
    check("mid_rst_ready", bus.CmdReady, 1);
    check("mid_rst_dec", bus.CntDec, 0);
    check("mid_rst_in", bus.CntIn, 0);
    check("mid_rst_steps", bus.Steps, 0);
    check("mid_rst_done", bus.Done, 0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    wait_ready();
    run_cmd(OP_INC, 2, 0, 2, 0, 21);
    repeat (5) @(posedge Clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command sequencer sitting in front of one dekatron `Counter` (IP, AP or loop counter). It accepts a single command (increment, decrement, set, or decrement-until-zero) with a repeat count. It then issues one-cycle `Request` pulses to the counter, waiting for `Ready` between steps, until the count is exhausted or the counter reports zero. It reports completion, the number of steps performed, and a stuck-counter timeout.

## Interface
- `DEKATRON_NUM`, 6: dekatrons in the driven counter.
- `DEKATRON_WIDTH`, 3: bits per dekatron; data width `DW = DEKATRON_NUM*DEKATRON_WIDTH`.
- `COUNT_WIDTH`, 8: width of repeat count and step counter.
- `TIMEOUT`, 15: maximum consecutive cycles waiting for `CntReady` before aborting (≥2).
- `Clk`  in  1  single clock, rising edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `CmdValid`  in  1  command offered.
- `CmdReady`  out  1  sequencer idle and accepting; a command is accepted when `CmdValid & CmdReady`.
- `CmdOp`  in  2  00 INC, 01 DEC, 10 SET, 11 DZ (decrement until zero).
- `CmdCount`  in  COUNT_WIDTH  repeat count for INC/DEC/DZ; ignored for SET.
- `CmdData`  in  DW  load value for SET.
- `CntRequest`  out  1  to counter `Request`.
- `CntDec`  out  1  to counter `Dec`.
- `CntSet`  out  1  to counter `Set`.
- `CntIn`  out  DW  to counter `In`.
- `CntReady`  in  1  from counter `Ready`.
- `CntZero`  in  1  from counter `Zero`.
- `Done`  out  1  one-cycle pulse at command end.
- `Error`  out  1  last command aborted on timeout; held until the next accept.
- `Steps`  out  COUNT_WIDTH  requests issued for the current or last command.

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, DONE. On reset all are held in IDLE.
- Reset values: `CmdReady`=1, `CntRequest`=0, `CntDec`=0, `CntSet`=0, `CntIn`=0, `Done`=0, `Error`=0, `Steps`=0.
- IDLE: `CmdReady`=1. On accept, the block:
  - latches op and data;
  - loads `remaining` = `CmdCount` (1 for SET);
  - clears `Steps`, `Error` and the timeout counter;
  - moves to CHECK.
  - `CmdValid` outside IDLE is ignored.
- `CntDec` = op∈{DEC, DZ}, `CntSet` = op==SET, and `CntIn` = latched data. These are driven from the accept edge until the return to IDLE and are stable around every request.
- CHECK:
  - If `remaining`==0, or op==DZ and `CntZero`==1: go to DONE.
  - Else if `CntReady`==1: go to ISSUE.
  - Else: stay and increment the timeout counter.
- ISSUE: `CntRequest`=1 for exactly this cycle. Decrement `remaining`, increment `Steps`, clear the timeout counter, go to WAIT.
- WAIT: `CntRequest`=0. When `CntReady`==1, go to CHECK. Otherwise increment the timeout counter.
- Timeout: if the counter reaches `TIMEOUT` in CHECK or WAIT, go to DONE with `Error`=1.
- DONE: `Done`=1 for one cycle, then IDLE.
- `Steps` wraps modulo 2^COUNT_WIDTH. It cannot exceed `CmdCount`, so no wrap occurs in normal use.
- DZ with `CntZero` already 1 at first CHECK: zero requests, `Steps`=0, no error.
- DZ with `CmdCount`=0: zero requests. The count bounds DZ in all cases.
- INC/DEC do not inspect `CntZero`. Counter wrap-around below 0 or above max is the counter's behaviour and is passed through.
- Reset asserted mid-command: immediate return to IDLE, `CntRequest` low asynchronously, no `Done`, and the counter value is left as is.

## Timing
- Accept at edge t: CHECK in cycle t+1.
- `CntRequest` is never high while `CntReady` was low at the preceding CHECK.
- `CntRequest` is never high on two consecutive cycles.
- At least one WAIT cycle separates consecutive requests.
- Per step: 1 CHECK + 1 ISSUE + k WAIT cycles, where k≥1 is the counter latency, so COUNT_DELAY=3 gives ≥5 cycles per step.
- Zero-step command: accept t, CHECK t+1, `Done` t+2, `CmdReady`=1 at t+3.
- Final `Done` follows the CHECK that observes `remaining`==0 (or zero / timeout) by one cycle.
- `Steps` and `Error` are valid in the `Done` cycle and hold until the next accept.
- Timeout fires after `TIMEOUT` consecutive non-ready cycles. `Done` follows one cycle later.

## Test plan
- Counter at 0, INC count 5 (real Counter, COUNT_DELAY=3): exactly 5 single-cycle `CntRequest` pulses, Out=5, `Steps`=5, one `Done`, `Error`=0.
- Counter at 3, DZ count 255: 3 requests, Out=0, `Steps`=3, `Done` once, `CntDec` high throughout.
- SET data 12345, `CmdCount`=200: exactly one request with `CntSet`=1, Out=12345, `Steps`=1.
- INC count 0: no `CntRequest`, `Done` at t+2, `CmdReady` back at t+3. `CmdValid` held during a running 4-step command: ignored, and the second command is accepted only after `Done`.
- Stub holds `CntReady`=0 after the first request, TIMEOUT=15: `Done` with `Error`=1, `Steps`=1, and `Error` clears on the next accept.
- `Rst_n` pulsed low during WAIT of a DEC count 10: outputs return to reset values immediately, no `Done`, and a fresh INC 2 then completes normally.
